alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles alu_Signal/alu_dataA/alu_dataB are held before alu_dataOut is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_funct  input  6  R-type funct code.
REQ-007 req_rs  input  32  first source operand.
REQ-008 req_rt  input  32  second source operand.
REQ-009 req_shamt  input  5  shift amount for SRL.
REQ-010 alu_dataA  output  32  operand A driven to the ALU.
REQ-011 alu_dataB  output  32  operand B driven to the ALU.
REQ-012 alu_Signal  output  3  ALU operation select.
REQ-013 alu_dataOut  input  32  ALU result, combinational from alu_* outputs.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  downstream accepts result.
REQ-016 rsp_data  output  32  captured ALU result.
REQ-017 rsp_err  output  1  illegal funct flag, qualified by rsp_valid.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, SETTLE, RESP; req_ready SHALL equal (state==IDLE).
REQ-020 IDLE: on req_valid&&req_ready, register alu_Signal/alu_dataA/alu_dataB per REQ-021, load settle counter with SETTLE_CYCLES, go SETTLE.
REQ-021 Decode: 0x24 AND->000, 0x25 OR->001, 0x20 ADD->010, 0x22 SUB->110, 0x2A SLT->111 (A=rs, B=rt); 0x02 SRL->101 with A=rt, B={27'b0,shamt}.
REQ-022 SETTLE: counter decrements each cycle; on the edge where counter==1, rsp_data<=alu_dataOut, go RESP.
REQ-023 Latency: rsp_valid SHALL rise exactly SETTLE_CYCLES+1 clocks after the accepting edge.
REQ-024 alu_dataA, alu_dataB, alu_Signal SHALL be stable from the accepting edge through the RESP handshake; in IDLE they retain last values.
REQ-025 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&&rsp_ready, then go IDLE in the next cycle (no back-to-back accept; one request in flight max).
REQ-026 rsp_ready held low SHALL stall RESP indefinitely without data change; req_valid during SETTLE/RESP is ignored (req_ready=0).
REQ-027 rsp_ready asserted before rsp_valid SHALL have no effect.
REQ-028 No arithmetic in this block; result width 32, no truncation or extension of alu_dataOut.

Reset
REQ-029 reset low SHALL immediately force state IDLE, req_ready=1 after release, rsp_valid=0, busy=0, rsp_err=0, rsp_data=0, alu_dataA=0, alu_dataB=0, alu_Signal=000, counter=0.
REQ-030 reset asserted mid-SETTLE or mid-RESP SHALL discard the in-flight request; no rsp_valid afterwards for it.
REQ-031 First request SHALL be accepted no earlier than the first rising edge after reset deasserts.

Configuration
REQ-032 Macro ALU_ISSUE_ILLEGAL_EN defined: funct outside REQ-021 set decodes as ADD, completes normally with rsp_err=1.
REQ-033 Macro ALU_ISSUE_ILLEGAL_EN undefined: illegal funct decodes as ADD, rsp_err tied 0, no error logic synthesised.

Verification
REQ-034 ADD: funct 0x20, rs=5, rt=7, SETTLE_CYCLES=2, rsp_ready=1 -> alu_Signal=010, rsp_valid 3 clocks after accept, rsp_data=12, rsp_err=0.
REQ-035 SUB/SLT: funct 0x22 rs=3 rt=10 -> rsp_data=0xFFFFFFF9; funct 0x2A rs=0xFFFFFFFF rt=1 -> alu_Signal=111, rsp_data=1.
REQ-036 SRL: funct 0x02, rt=0x80000000, shamt=4 -> alu_dataA=0x80000000, alu_dataB=4, alu_Signal=101, rsp_data=0x08000000.
REQ-037 Backpressure: AND rs=0xF0F0 rt=0xFF00, rsp_ready low 5 cycles -> rsp_valid and rsp_data=0xF000 held 5 cycles, req_ready=0 throughout, second req_valid not accepted until cycle after handshake.
REQ-038 Reset mid-op: assert reset during SETTLE -> outputs per REQ-029 immediately, rsp_valid never asserts for that request.
REQ-039 Illegal funct 0x3F rs=1 rt=1 -> rsp_data=2; rsp_err=1 with ALU_ISSUE_ILLEGAL_EN, rsp_err=0 without.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issues one R-type operation to an external combinational ALU, waits a fixed settle time,
// captures the result and holds it until downstream accepts. Optional build macro: ALU_ISSUE_ILLEGAL_EN.
module alu_issue #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic [4:0]  req_shamt,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [2:0]  alu_Signal,
  input  logic [31:0] alu_dataOut,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic [31:0] a_r, b_r, data_r;
  logic [2:0]  sig_r;
  logic        valid_r, ready_r, busy_r;

  logic [31:0] a_s, b_s;
  logic [2:0]  sig_s;
  logic        accept_s, capture_s;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h02: funct_legal = 1'b1;
      default:                                  funct_legal = 1'b0;
    endcase
  endfunction

  assign accept_s  = req_valid && ready_r;
  assign capture_s = (state_r == SETTLE) && (cnt_r == 4'd1);

  // Funct decode; anything unrecognised runs as ADD on rs/rt.
  always_comb begin
    a_s   = req_rs;
    b_s   = req_rt;
    sig_s = 3'b010;
    case (req_funct)
      6'h24:   sig_s = 3'b000;
      6'h25:   sig_s = 3'b001;
      6'h20:   sig_s = 3'b010;
      6'h22:   sig_s = 3'b110;
      6'h2A:   sig_s = 3'b111;
      6'h02: begin
        sig_s = 3'b101;
        a_s   = req_rt;
        b_s   = {27'd0, req_shamt};
      end
      default: sig_s = 3'b010;
    endcase
  end

  // Request sequencing: IDLE -> SETTLE (ALU inputs held) -> RESP (result held until taken).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sig_r   <= 3'b000;
      data_r  <= 32'd0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a_s;
            b_r     <= b_s;
            sig_r   <= sig_s;
            cnt_r   <= SETTLE_LD;
            state_r <= SETTLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        SETTLE: begin
          if (capture_s) begin
            data_r  <= alu_dataOut;
            valid_r <= 1'b1;
            cnt_r   <= 4'd0;
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic illegal_s;
  logic ill_r, err_r;

  assign illegal_s = !funct_legal(req_funct);

  // Illegal flag travels with the request and is published together with the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ill_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && accept_s) ill_r <= illegal_s;
      if (capture_s)                     err_r <= ill_r;
    end
  end

  assign rsp_err = err_r;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready  = ready_r;
  assign busy       = busy_r;
  assign rsp_valid  = valid_r;
  assign rsp_data   = data_r;
  assign alu_dataA  = a_r;
  assign alu_dataB  = b_r;
  assign alu_Signal = sig_r;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed spec cases plus randomized ops against a funct-level model.
module tb_alu_issue;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_funct = 6'h00;
  logic [31:0] req_rs = 32'd0, req_rt = 32'd0;
  logic [4:0]  req_shamt = 5'd0;
  logic [31:0] alu_dataA, alu_dataB, alu_dataOut;
  logic [2:0]  alu_Signal;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue #(.SETTLE_CYCLES(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_rs(req_rs), .req_rt(req_rt), .req_shamt(req_shamt),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_Signal(alu_Signal),
    .alu_dataOut(alu_dataOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // External combinational ALU driven by the DUT's alu_* outputs.
  always_comb begin
    case (alu_Signal)
      3'b000:  alu_dataOut = alu_dataA & alu_dataB;
      3'b001:  alu_dataOut = alu_dataA | alu_dataB;
      3'b010:  alu_dataOut = alu_dataA + alu_dataB;
      3'b110:  alu_dataOut = alu_dataA - alu_dataB;
      3'b111:  alu_dataOut = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
      3'b101:  alu_dataOut = alu_dataA >> alu_dataB[4:0];
      default: alu_dataOut = 32'hDEADBEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what the instruction means, independent of how the block encodes it.
  function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [4:0] sh);
    case (f)
      6'h24:   return rs & rt;
      6'h25:   return rs | rt;
      6'h20:   return rs + rt;
      6'h22:   return rs - rt;
      6'h2A:   return ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      6'h02:   return rt >> sh;
      default: return rs + rt;
    endcase
  endfunction

  function automatic logic [2:0] ref_sig(input logic [5:0] f);
    case (f)
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h22:   return 3'b110;
      6'h2A:   return 3'b111;
      6'h02:   return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic ref_err(input logic [5:0] f);
`ifdef ALU_ISSUE_ILLEGAL_EN
    case (f)
      6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h02: return 1'b0;
      default:                                  return 1'b1;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input int stall);
    logic [31:0] ea, eb, er;
    logic [2:0]  es;
    int lat, w;
    ea = (f == 6'h02) ? rt : rs;
    eb = (f == 6'h02) ? {27'd0, sh} : rt;
    es = ref_sig(f);
    er = ref_result(f, rs, rt, sh);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_funct = f; req_rs = rs; req_rt = rt; req_shamt = sh;
    rsp_ready = (stall == 0);
    @(negedge clk);
    // Cycle 1 after accept: keep a competing request present in stalled runs.
    if (stall > 0) begin
      req_funct = 6'h22; req_rs = ~rs; req_rt = ~rt;
    end else begin
      req_valid = 1'b0;
    end
    check("alu_Signal", {29'd0, alu_Signal}, {29'd0, es});
    check("alu_dataA", alu_dataA, ea);
    check("alu_dataB", alu_dataB, eb);
    check("busy_settle", {31'd0, busy}, 32'd1);
    check("ready_settle", {31'd0, req_ready}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(N + 1));
    check("rsp_data", rsp_data, er);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, ref_err(f)});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, er);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
      check("stall_sig", {29'd0, alu_Signal}, {29'd0, es});
      check("stall_dataA", alu_dataA, ea);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_ready", {31'd0, req_ready}, 32'd1);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("idle_dataA", alu_dataA, ea);
    check("idle_dataB", alu_dataB, eb);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_data"}, rsp_data, 32'd0);
    check({tag, "_dataA"}, alu_dataA, 32'd0);
    check({tag, "_dataB"}, alu_dataB, 32'd0);
    check({tag, "_sig"}, {29'd0, alu_Signal}, 32'd0);
  endtask

  initial begin
    logic [5:0] fl [7];
    int seen;
    fl[0] = 6'h24; fl[1] = 6'h25; fl[2] = 6'h20; fl[3] = 6'h22;
    fl[4] = 6'h2A; fl[5] = 6'h02; fl[6] = 6'h3F;

    // Reset held low with a request pending: nothing may be accepted.
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    do_op(6'h20, 32'd5, 32'd7, 5'd0, 0);
    check("add_12", rsp_data, 32'd12);
    do_op(6'h22, 32'd3, 32'd10, 5'd0, 0);
    do_op(6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
    do_op(6'h02, 32'd0, 32'h80000000, 5'd4, 0);
    do_op(6'h24, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5);
    do_op(6'h3F, 32'd1, 32'd1, 5'd0, 0);

    // Reset during SETTLE discards the request.
    req_valid = 1'b1; req_funct = 6'h20; req_rs = 32'd9; req_rt = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    rsp_ready = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    rsp_ready = 1'b0;

    for (int i = 0; i < 30; i++) begin
      do_op(fl[$urandom_range(0, 6)], $urandom, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
